// File: rtl/gcd_microprocessor.sv
// 8-bit accumulator processor whose memory resets to a GCD-by-subtraction program.
module gcd_microprocessor #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] dataIn,
  output logic              Halt,
  output logic [2:0]        IR,
  output logic [DATA_W-1:0] dataOut
);

  localparam int unsigned OPC_W = 3;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [OPC_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_STORE = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OPC_W-1:0] OP_INPUT = 3'b100;
  localparam logic [OPC_W-1:0] OP_JZ    = 3'b101;
  localparam logic [OPC_W-1:0] OP_JPOS  = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_INPUT_WAIT,
    S_INPUT_RELEASE,
    S_HALT
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [DATA_W-1:0]   ir, ir_n;
  logic [DATA_W-1:0]   acc, acc_n;
  logic                halt_q;
  logic                mem_we;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [OPC_W-1:0]    opc;
  logic [ADDR_W-1:0]   opa;
  logic [DATA_W-1:0]   mem_rd;

  // Built-in GCD program: X -> 1E, Y -> 1F, subtract the smaller from the larger until equal.
  function automatic logic [DATA_W-1:0] prog_word(input int unsigned addr);
    logic [7:0] w;
    case (addr)
      0:  w = 8'h80; // INPUT
      1:  w = 8'h3E; // STORE 1E
      2:  w = 8'h80; // INPUT
      3:  w = 8'h3F; // STORE 1F
      4:  w = 8'h1E; // LOAD 1E
      5:  w = 8'h7F; // SUB 1F
      6:  w = 8'hAE; // JZ 0E
      7:  w = 8'hCC; // JPOS 0C
      8:  w = 8'h1F; // LOAD 1F
      9:  w = 8'h7E; // SUB 1E
      10: w = 8'h3F; // STORE 1F
      11: w = 8'hC4; // JPOS 04
      12: w = 8'h3E; // STORE 1E
      13: w = 8'hC4; // JPOS 04
      14: w = 8'h1E; // LOAD 1E
      15: w = 8'hE0; // HALT
      default: w = 8'h00;
    endcase
    return DATA_W'(w);
  endfunction

  assign opc    = ir[DATA_W-1 -: OPC_W];
  assign opa    = ir[ADDR_W-1:0];
  assign mem_rd = mem[opa];

  // Control state and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      acc    <= '0;
      halt_q <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ir     <= ir_n;
      acc    <= acc_n;
      halt_q <= (state_n == S_HALT);
    end
  end

  // Unified memory: reset reloads the program, STORE writes synchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= prog_word(i);
      end
    end else if (mem_we) begin
      mem[opa] <= acc;
    end
  end

  // Next-state and datapath updates for each control step.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    acc_n   = acc;
    mem_we  = 1'b0;
    case (state)
      S_FETCH: begin
        ir_n    = mem[pc];
        pc_n    = pc + ADDR_W'(1);
        state_n = S_DECODE;
      end
      S_DECODE: begin
        case (opc)
          OP_INPUT: state_n = S_INPUT_WAIT;
          OP_HALT:  state_n = S_HALT;
          default:  state_n = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        state_n = S_FETCH;
        case (opc)
          OP_LOAD:  acc_n  = mem_rd;
          OP_STORE: mem_we = 1'b1;
          OP_ADD:   acc_n  = acc + mem_rd;
          OP_SUB:   acc_n  = acc - mem_rd;
          OP_JZ:    if (acc == '0) pc_n = opa;
          OP_JPOS:  if (!acc[DATA_W-1] && (acc != '0)) pc_n = opa;
          default:  ;
        endcase
      end
      S_INPUT_WAIT: begin
        if (enter) begin
          acc_n   = dataIn;
          state_n = S_INPUT_RELEASE;
        end
      end
      S_INPUT_RELEASE: begin
        // Wait for enter to drop so one pulse loads exactly one value.
        if (!enter) state_n = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  assign Halt    = halt_q;
  assign IR      = opc;
  assign dataOut = acc;

endmodule

// File: tb/tb_gcd_microprocessor.sv
// Directed bench for gcd_microprocessor: feeds operand pairs and checks GCD at halt.
module tb_gcd_microprocessor;

  logic       clk;
  logic       rst;
  logic       enter;
  logic [7:0] dataIn;
  logic       Halt;
  logic [2:0] IR;
  logic [7:0] dataOut;

  int total = 0;
  int bad   = 0;

  gcd_microprocessor dut (
    .clock   (clk),
    .reset   (rst),
    .enter   (enter),
    .dataIn  (dataIn),
    .Halt    (Halt),
    .IR      (IR),
    .dataOut (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    enter  = 1'b0;
    dataIn = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Eight low cycles leave time to reach INPUT_WAIT, then enter is held for hi cycles.
  task automatic feed(input logic [7:0] v, input int hi);
    repeat (8) @(negedge clk);
    dataIn = v;
    enter  = 1'b1;
    repeat (hi) @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!Halt && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_gcd(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp);
    int cyc;
    do_reset();
    feed(x, 3);
    feed(y, 3);
    wait_halt(cyc);
    check({tag, "_halt"}, 32'(Halt), 32'd1);
    check({tag, "_gcd"}, 32'(dataOut), 32'(exp));
  endtask

  initial begin
    int cyc;
    rst    = 1'b1;
    enter  = 1'b0;
    dataIn = 8'd0;
    #1;
    check("rst_halt", 32'(Halt), 32'd0);
    check("rst_ir", 32'(IR), 32'd0);
    check("rst_dout", 32'(dataOut), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle with no enter: parked on the first INPUT.
    repeat (50) @(negedge clk);
    check("idle_ir", 32'(IR), 32'd4);
    check("idle_halt", 32'(Halt), 32'd0);
    check("idle_dout", 32'(dataOut), 32'd0);

    run_gcd("g51_22", 8'd51, 8'd22, 8'd1);
    check("g51_22_ir", 32'(IR), 32'd7);
    repeat (20) @(negedge clk);
    check("g51_22_hold_halt", 32'(Halt), 32'd1);
    check("g51_22_hold_dout", 32'(dataOut), 32'd1);

    run_gcd("g12_18", 8'd12, 8'd18, 8'd6);
    run_gcd("g18_12", 8'd18, 8'd12, 8'd6);

    // Equal operands: JZ taken on first compare, short path to halt.
    do_reset();
    feed(8'd7, 3);
    feed(8'd7, 3);
    wait_halt(cyc);
    check("g7_7_halt", 32'(Halt), 32'd1);
    check("g7_7_gcd", 32'(dataOut), 32'd7);
    check("g7_7_fast", 32'(cyc <= 30), 32'd1);

    // Long enter pulse must load only X; processor then waits for the second pulse.
    do_reset();
    feed(8'd40, 20);
    repeat (30) @(negedge clk);
    check("long_nohalt", 32'(Halt), 32'd0);
    check("long_ir", 32'(IR), 32'd4);
    check("long_acc", 32'(dataOut), 32'd40);
    feed(8'd40, 3);
    wait_halt(cyc);
    check("long_halt", 32'(Halt), 32'd1);
    check("long_gcd", 32'(dataOut), 32'd40);

    // Reset while waiting for Y discards the pending X.
    do_reset();
    feed(8'd100, 3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_halt", 32'(Halt), 32'd0);
    check("midrst_dout", 32'(dataOut), 32'd0);
    check("midrst_ir", 32'(IR), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    feed(8'd100, 3);
    repeat (4) @(negedge clk);
    check("midrst_run_halt", 32'(Halt), 32'd0);
    feed(8'd75, 3);
    wait_halt(cyc);
    check("g100_75_halt", 32'(Halt), 32'd1);
    check("g100_75_gcd", 32'(dataOut), 32'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
